bus_dest_regfile: RTL and testbench

Destination end of the datapath bus. Captures the 32-bit bus value into R0–R15, HI, LO, PC and MAR under control-unit strobes, and turns the control unit's one-hot "out" strobes into the 5-bit source select consumed by the 32:1 bus multiplexer. It decodes register numbers from IR fields, provides the sign-extended constant C, and flags multiple-driver bus conflicts. It sits between the control unit and the bus multiplexer and owns all architected bus-visible storage except Z and MDR.

---
 rtl/bus_dest_regfile.sv | 138 +++++++++++++
 tb/tb_bus_dest_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bus_dest_regfile.sv
// Bus destination register file: R0-R15, HI, LO, PC, MAR, source-select encoder, conflict flag.
// Optional: define R0_ZERO_GATE_EN to make a base-address read of R0 put 0 on the bus.

module gpr_reg (
   input  logic        clk,
   input  logic        clr,
   input  logic        we,
   input  logic [31:0] d,
   output logic [31:0] q
);
   always_ff @(posedge clk or posedge clr) begin
      if (clr)     q <= '0;
      else if (we) q <= d;
   end
endmodule

module bus_dest_regfile (
   input  logic         clk,
   input  logic         clr,
   input  logic [31:0]  bus_in,
   input  logic [31:0]  ir,
   input  logic         gra,
   input  logic         grb,
   input  logic         grc,
   input  logic         r_in,
   input  logic         r_out,
   input  logic         ba_out,
   input  logic         hi_in,
   input  logic         lo_in,
   input  logic         pc_in,
   input  logic         pc_inc,
   input  logic         mar_in,
   input  logic         hi_out,
   input  logic         lo_out,
   input  logic         zhi_out,
   input  logic         zlo_out,
   input  logic         pc_out,
   input  logic         mdr_out,
   input  logic         inport_out,
   input  logic         c_out,
   output logic [511:0] gpr_flat,
   output logic [31:0]  hi,
   output logic [31:0]  lo,
   output logic [31:0]  pc,
   output logic [31:0]  mar,
   output logic [31:0]  c_sign_extended,
   output logic [4:0]   bus_select,
   output logic         bus_conflict
);
   localparam int NUM_GPR = 16;

   localparam logic [4:0] SEL_HI   = 5'd16;
   localparam logic [4:0] SEL_LO   = 5'd17;
   localparam logic [4:0] SEL_ZHI  = 5'd18;
   localparam logic [4:0] SEL_ZLO  = 5'd19;
   localparam logic [4:0] SEL_PC   = 5'd20;
   localparam logic [4:0] SEL_MDR  = 5'd21;
   localparam logic [4:0] SEL_IN   = 5'd22;
   localparam logic [4:0] SEL_C    = 5'd23;
   localparam logic [4:0] SEL_NONE = 5'd31;

   logic [NUM_GPR-1:0][31:0] gpr;
   logic [3:0]               idx;
   logic                     idx_vld;
   logic                     gpr_rd;
   logic                     gpr_zero;
   logic [8:0]               src;
   logic                     multi_src;

   always_comb begin
      idx     = 4'd0;
      idx_vld = 1'b1;
      if (gra)      idx = ir[26:23];
      else if (grb) idx = ir[22:19];
      else if (grc) idx = ir[18:15];
      else          idx_vld = 1'b0;
   end

   assign gpr_rd = (r_out | ba_out) & idx_vld;

`ifdef R0_ZERO_GATE_EN
   // Base-address read of R0 yields zero; an explicit r_out still reads the real R0.
   assign gpr_zero = ba_out & ~r_out & idx_vld & (idx == 4'd0);
`else
   assign gpr_zero = 1'b0;
`endif

   always_comb begin
      bus_select = SEL_NONE;
      if (gpr_rd)          bus_select = gpr_zero ? SEL_NONE : {1'b0, idx};
      else if (hi_out)     bus_select = SEL_HI;
      else if (lo_out)     bus_select = SEL_LO;
      else if (zhi_out)    bus_select = SEL_ZHI;
      else if (zlo_out)    bus_select = SEL_ZLO;
      else if (pc_out)     bus_select = SEL_PC;
      else if (mdr_out)    bus_select = SEL_MDR;
      else if (inport_out) bus_select = SEL_IN;
      else if (c_out)      bus_select = SEL_C;
   end

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign src       = {gpr_rd, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out};
   assign multi_src = |(src & (src - 9'd1));

   assign c_sign_extended = {{13{ir[18]}}, ir[18:0]};

   genvar g;
   generate
      for (g = 0; g < NUM_GPR; g++) begin : g_gpr
         gpr_reg u_gpr (
            .clk (clk),
            .clr (clr),
            .we  (r_in & idx_vld & (idx == 4'(g))),
            .d   (bus_in),
            .q   (gpr[g])
         );
      end
   endgenerate

   assign gpr_flat = gpr;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hi           <= '0;
         lo           <= '0;
         mar          <= '0;
         pc           <= '0;
         bus_conflict <= 1'b0;
      end else begin
         if (hi_in)  hi  <= bus_in;
         if (lo_in)  lo  <= bus_in;
         if (mar_in) mar <= bus_in;
         if (pc_in)       pc <= bus_in;
         else if (pc_inc) pc <= pc + 32'd1;
         if (multi_src) bus_conflict <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bus_dest_regfile.sv
// Directed self-checking bench for bus_dest_regfile; honours R0_ZERO_GATE_EN for the R0 gating case.

module tb_bus_dest_regfile;
   logic         clk = 1'b0;
   logic         clr;
   logic [31:0]  bus_in, ir;
   logic         gra, grb, grc, r_in, r_out, ba_out;
   logic         hi_in, lo_in, pc_in, pc_inc, mar_in;
   logic         hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
   logic [511:0] gpr_flat;
   logic [31:0]  hi, lo, pc, mar, c_sign_extended;
   logic [4:0]   bus_select;
   logic         bus_conflict;

   int errors = 0;
   int checks = 0;

   bus_dest_regfile dut (
      .clk(clk), .clr(clr), .bus_in(bus_in), .ir(ir),
      .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
      .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .pc_inc(pc_inc), .mar_in(mar_in),
      .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
      .pc_out(pc_out), .mdr_out(mdr_out), .inport_out(inport_out), .c_out(c_out),
      .gpr_flat(gpr_flat), .hi(hi), .lo(lo), .pc(pc), .mar(mar),
      .c_sign_extended(c_sign_extended), .bus_select(bus_select), .bus_conflict(bus_conflict)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk_ir(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
      return {5'b0, ra, rb, rc, 15'b0};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      {gra, grb, grc, r_in, r_out, ba_out} = '0;
      {hi_in, lo_in, pc_in, pc_inc, mar_in} = '0;
      {hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out} = '0;
      #1;
   endtask

   task automatic test_reset;
      clr = 1'b1; bus_in = '0; ir = '0;
      idle();
      checks++; if (gpr_flat !== '0) begin errors++; $display("FAIL reset_gpr got %h exp 0", gpr_flat[31:0]); end
      checks++; if ({hi, lo, pc, mar} !== '0) begin errors++; $display("FAIL reset_regs got %h %h %h %h exp 0", hi, lo, pc, mar); end
      checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b exp 0", bus_conflict); end
      checks++; if (bus_select !== 5'd31) begin errors++; $display("FAIL reset_sel got %0d exp 31", bus_select); end
      tick(); clr = 1'b0;
      // Write R5 and PC, and cause a conflict, then clear mid-cycle.
      ir = mk_ir(4'd5, 4'd0, 4'd0); gra = 1; r_in = 1; pc_in = 1; hi_out = 1; lo_out = 1;
      bus_in = 32'h1234_5678;
      tick();
      checks++; if (gpr_flat[191:160] !== 32'h1234_5678) begin errors++; $display("FAIL r5_write got %h exp 12345678", gpr_flat[191:160]); end
      checks++; if (pc !== 32'h1234_5678 || bus_conflict !== 1'b1) begin errors++; $display("FAIL pre_clr got pc=%h cf=%b exp 12345678 1", pc, bus_conflict); end
      idle();
      hi_out = 1;
      #2 clr = 1'b1;
      #1;
      checks++; if (gpr_flat[191:160] !== 32'h0 || pc !== 32'h0 || bus_conflict !== 1'b0) begin
         errors++; $display("FAIL async_clr got r5=%h pc=%h cf=%b exp 0 0 0", gpr_flat[191:160], pc, bus_conflict); end
      checks++; if (bus_select !== 5'd16) begin errors++; $display("FAIL sel_during_clr got %0d exp 16", bus_select); end
      tick(); clr = 1'b0; idle();
   endtask

   task automatic test_gpr;
      ir = mk_ir(4'd7, 4'd2, 4'd3); gra = 1; r_in = 1; bus_in = 32'hDEAD_BEEF;
      tick();
      checks++; if (gpr_flat[255:224] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL r7_write got %h exp deadbeef", gpr_flat[255:224]); end
      r_in = 0; r_out = 1; #1;
      checks++; if (bus_select !== 5'd7) begin errors++; $display("FAIL sel_ra got %0d exp 7", bus_select); end
      gra = 0; grb = 1; #1;
      checks++; if (bus_select !== 5'd2) begin errors++; $display("FAIL sel_rb got %0d exp 2", bus_select); end
      grb = 0; grc = 1; #1;
      checks++; if (bus_select !== 5'd3) begin errors++; $display("FAIL sel_rc got %0d exp 3", bus_select); end
      grc = 0; #1;
      checks++; if (bus_select !== 5'd31) begin errors++; $display("FAIL sel_noidx got %0d exp 31", bus_select); end
      r_out = 0; grb = 1; r_in = 1; bus_in = 32'hA5A5_0F0F;
      tick();
      checks++; if (gpr_flat[95:64] !== 32'hA5A5_0F0F) begin errors++; $display("FAIL r2_write got %h exp a5a50f0f", gpr_flat[95:64]); end
      // r_in without any index must not write.
      grb = 0; bus_in = 32'hFFFF_FFFF;
      tick();
      checks++; if (gpr_flat[255:224] !== 32'hDEAD_BEEF || gpr_flat[31:0] !== 32'h0) begin
         errors++; $display("FAIL noidx_write got r7=%h r0=%h exp deadbeef 0", gpr_flat[255:224], gpr_flat[31:0]); end
      // Self-transfer: old value selected now, new value after the edge.
      gra = 1; r_out = 1; bus_in = 32'h0BAD_F00D; #1;
      checks++; if (bus_select !== 5'd7 || gpr_flat[255:224] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL self_pre got sel=%0d r7=%h exp 7 deadbeef", bus_select, gpr_flat[255:224]); end
      tick();
      checks++; if (gpr_flat[255:224] !== 32'h0BAD_F00D) begin errors++; $display("FAIL self_post got %h exp 0badf00d", gpr_flat[255:224]); end
      idle();
   endtask

   task automatic test_capture;
      hi_in = 1; bus_in = 32'h1111_0001; tick(); hi_in = 0;
      lo_in = 1; bus_in = 32'h2222_0002; tick(); lo_in = 0;
      mar_in = 1; bus_in = 32'h3333_0003; tick(); mar_in = 0;
      checks++; if (hi !== 32'h1111_0001 || lo !== 32'h2222_0002 || mar !== 32'h3333_0003) begin
         errors++; $display("FAIL capture got hi=%h lo=%h mar=%h exp 11110001 22220002 33330003", hi, lo, mar); end
      idle();
   endtask

   task automatic test_pc;
      pc_in = 1; bus_in = 32'hFFFF_FFFF; tick(); pc_in = 0;
      checks++; if (pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL pc_load got %h exp ffffffff", pc); end
      pc_inc = 1; tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 0", pc); end
      tick();
      checks++; if (pc !== 32'h1) begin errors++; $display("FAIL pc_inc got %h exp 1", pc); end
      pc_in = 1; bus_in = 32'h100; tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL pc_prio got %h exp 100", pc); end
      idle();
   endtask

   task automatic test_priority_conflict;
      checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL cf_clean got %b exp 0", bus_conflict); end
      // r_out with no index is not a source.
      r_out = 1; hi_out = 1; #1;
      checks++; if (bus_select !== 5'd16) begin errors++; $display("FAIL sel_hi got %0d exp 16", bus_select); end
      tick();
      checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL cf_noidx got %b exp 0", bus_conflict); end
      // r_out plus ba_out on the same register is a single source.
      hi_out = 0; ir = mk_ir(4'd7, 4'd0, 4'd0); gra = 1; ba_out = 1; tick();
      checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL cf_rba got %b exp 0", bus_conflict); end
      idle();
      zhi_out = 1; pc_out = 1; #1;
      checks++; if (bus_select !== 5'd18) begin errors++; $display("FAIL sel_zhi got %0d exp 18", bus_select); end
      zhi_out = 0; #1;
      checks++; if (bus_select !== 5'd20) begin errors++; $display("FAIL sel_pc got %0d exp 20", bus_select); end
      pc_out = 0; zlo_out = 1; mdr_out = 1; #1;
      checks++; if (bus_select !== 5'd19) begin errors++; $display("FAIL sel_zlo got %0d exp 19", bus_select); end
      zlo_out = 0; inport_out = 1; #1;
      checks++; if (bus_select !== 5'd21) begin errors++; $display("FAIL sel_mdr got %0d exp 21", bus_select); end
      mdr_out = 0; c_out = 1; #1;
      checks++; if (bus_select !== 5'd22) begin errors++; $display("FAIL sel_in got %0d exp 22", bus_select); end
      inport_out = 0; #1;
      checks++; if (bus_select !== 5'd23) begin errors++; $display("FAIL sel_c got %0d exp 23", bus_select); end
      lo_out = 1; #1;
      checks++; if (bus_select !== 5'd17) begin errors++; $display("FAIL sel_lo got %0d exp 17", bus_select); end
      tick();
      checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL cf_set got %b exp 1", bus_conflict); end
      idle(); tick();
      checks++; if (bus_conflict !== 1'b1) begin errors++; $display("FAIL cf_sticky got %b exp 1", bus_conflict); end
      #2 clr = 1'b1; #1;
      checks++; if (bus_conflict !== 1'b0) begin errors++; $display("FAIL cf_clr got %b exp 0", bus_conflict); end
      tick(); clr = 1'b0;
   endtask

   task automatic test_c_default;
      idle();
      ir = 32'h0004_0000; #1;
      checks++; if (c_sign_extended !== 32'hFFFC_0000) begin errors++; $display("FAIL c_neg got %h exp fffc0000", c_sign_extended); end
      ir = 32'hFFFB_FFFF; #1;
      checks++; if (c_sign_extended !== 32'h0003_FFFF) begin errors++; $display("FAIL c_pos got %h exp 0003ffff", c_sign_extended); end
      checks++; if (bus_select !== 5'd31) begin errors++; $display("FAIL sel_idle got %0d exp 31", bus_select); end
   endtask

   task automatic test_r0_gate;
      logic [4:0] exp_ba;
`ifdef R0_ZERO_GATE_EN
      exp_ba = 5'd31;
`else
      exp_ba = 5'd0;
`endif
      ir = mk_ir(4'd0, 4'd0, 4'd0); gra = 1; r_in = 1; bus_in = 32'h55; tick(); r_in = 0;
      checks++; if (gpr_flat[31:0] !== 32'h55) begin errors++; $display("FAIL r0_write got %h exp 55", gpr_flat[31:0]); end
      ba_out = 1; #1;
      checks++; if (bus_select !== exp_ba) begin errors++; $display("FAIL r0_ba got %0d exp %0d", bus_select, exp_ba); end
      ba_out = 0; r_out = 1; #1;
      checks++; if (bus_select !== 5'd0) begin errors++; $display("FAIL r0_rout got %0d exp 0", bus_select); end
      idle();
   endtask

   initial begin
      test_reset();
      test_gpr();
      test_capture();
      test_pc();
      test_priority_conflict();
      test_c_default();
      test_r0_gate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
